// File: rtl/row_accumulator_axis.sv
// row_accumulator_axis
// Sums LANES signed elements per input beat, then accumulates M_SIZE beats
// into one row sum. The row sum goes out on an AXI-Stream master. Row and
// frame boundaries travel with the data: s_tlast closes a row early and
// marks the frame end.
// Optional build macro: ACC_SATURATE_EN. When it is defined, the accumulator
// clamps at the signed ACC_WIDTH limits instead of wrapping.
module row_accumulator_axis #(
   parameter int D_WIDTH   = 32,
   parameter int LANES     = 4,
   parameter int M_SIZE    = 4,
   parameter int ACC_WIDTH = 40
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [LANES*D_WIDTH-1:0]   s_tdata,
   input  logic                       s_tvalid,
   input  logic                       s_tlast,
   output logic                       s_tready,
   output logic [ACC_WIDTH-1:0]       m_tdata,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic                       m_tlast,
   output logic                       m_tuser,
   output logic                       o_overflow
);

   localparam int CNT_W = (M_SIZE > 1) ? $clog2(M_SIZE) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(M_SIZE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef ACC_SATURATE_EN
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

   // Sign-extend one element to the accumulator width.
   function automatic logic [ACC_WIDTH-1:0] sign_ext(input logic signed [D_WIDTH-1:0] elem);
      return ACC_WIDTH'(elem);
   endfunction

   // Signed add overflow: equal operand signs produce a result of the other sign.
   function automatic logic add_ovf(input logic [ACC_WIDTH-1:0] a,
                                    input logic [ACC_WIDTH-1:0] b,
                                    input logic [ACC_WIDTH-1:0] s);
      return (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
   endfunction

   logic                 en_s;
   logic                 close_s;
   logic [ACC_WIDTH-1:0] lane_sum_s;
   logic [ACC_WIDTH-1:0] sum_s;
   logic [ACC_WIDTH-1:0] res_s;
   logic                 ovf_s;

   logic [CNT_W-1:0]     cnt_r;
   logic                 s1_valid_r;
   logic [ACC_WIDTH-1:0] s1_sum_r;
   logic                 s1_close_r;
   logic                 s1_last_r;
   logic                 s1_full_r;
   logic [ACC_WIDTH-1:0] acc_r;
   logic [ACC_WIDTH-1:0] m_tdata_r;
   logic                 m_tvalid_r;
   logic                 m_tlast_r;
   logic                 m_tuser_r;
   logic                 overflow_r;

   // The whole pipeline advances together; it stalls only while a result is stuck.
   assign en_s     = !m_tvalid_r || m_tready;
   assign s_tready = en_s;
   assign close_s  = (cnt_r == CNT_MAX) || s_tlast;

   assign m_tdata    = m_tdata_r;
   assign m_tvalid   = m_tvalid_r;
   assign m_tlast    = m_tlast_r;
   assign m_tuser    = m_tuser_r;
   assign o_overflow = overflow_r;

   // Stage-1 combinational lane sum. The width constraint guarantees it cannot overflow.
   always_comb begin
      lane_sum_s = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_sum_s = lane_sum_s + sign_ext(s_tdata[l*D_WIDTH +: D_WIDTH]);
      end
   end

   // Stage-2 add, overflow detection, and optional clamping.
   always_comb begin
      sum_s = acc_r + s1_sum_r;
      ovf_s = add_ovf(acc_r, s1_sum_r, sum_s);
`ifdef ACC_SATURATE_EN
      if (ovf_s) begin
         if (acc_r[ACC_WIDTH-1]) begin
            res_s = ACC_MIN;
         end else begin
            res_s = ACC_MAX;
         end
      end else begin
         res_s = sum_s;
      end
`else
      res_s = sum_s;
`endif
   end

   // Stage-1 registers and the beat-within-row counter.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_r      <= '0;
         s1_valid_r <= 1'b0;
         s1_sum_r   <= '0;
         s1_close_r <= 1'b0;
         s1_last_r  <= 1'b0;
         s1_full_r  <= 1'b0;
      end else if (en_s) begin
         s1_valid_r <= s_tvalid;
         if (s_tvalid) begin
            s1_sum_r   <= lane_sum_s;
            s1_close_r <= close_s;
            s1_last_r  <= s_tlast;
            s1_full_r  <= (cnt_r == CNT_MAX);
            if (close_s) begin
               cnt_r <= '0;
            end else begin
               cnt_r <= cnt_r + CNT_ONE;
            end
         end
      end
   end

   // Stage-2 accumulator and output register. A new result may replace one
   // that is handed off on the same edge, so no bubble appears.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         acc_r      <= '0;
         m_tdata_r  <= '0;
         m_tvalid_r <= 1'b0;
         m_tlast_r  <= 1'b0;
         m_tuser_r  <= 1'b0;
      end else if (en_s) begin
         if (s1_valid_r && s1_close_r) begin
            m_tdata_r  <= res_s;
            m_tvalid_r <= 1'b1;
            m_tlast_r  <= s1_last_r;
            m_tuser_r  <= s1_last_r && !s1_full_r;
            acc_r      <= '0;
         end else begin
            m_tvalid_r <= 1'b0;
            if (s1_valid_r) begin
               acc_r <= res_s;
            end
         end
      end
   end

   // Sticky overflow flag. Only reset clears it.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         overflow_r <= 1'b0;
      end else if (en_s && s1_valid_r && ovf_s) begin
         overflow_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_row_accumulator_axis.sv
// Self-checking bench for row_accumulator_axis. The main instance uses the
// default parameters and is compared against a queue-based row-sum model.
// A second instance (D_WIDTH=8, ACC_WIDTH=10) exercises overflow.
module tb_row_accumulator_axis;

   typedef struct {
      logic [127:0] data;
      logic         last;
   } beat_t;

   typedef struct {
      logic [39:0] data;
      logic        last;
      logic        user;
   } res_t;

   logic         aclk = 1'b0;
   logic         aresetn;
   logic [127:0] s_tdata;
   logic         s_tvalid, s_tlast, s_tready;
   logic [39:0]  m_tdata;
   logic         m_tvalid, m_tready, m_tlast, m_tuser, o_overflow;

   logic [31:0]  s2_tdata;
   logic         s2_tvalid, s2_tlast, s2_tready;
   logic [9:0]   m2_tdata;
   logic         m2_tvalid, m2_tready, m2_tlast, m2_tuser, o2_overflow;

   int checks = 0;
   int errors = 0;
   int cyc = 0, in_cnt = 0, in_cyc = 0, out_cyc = 0, stall_cnt = 0;
   beat_t tx_q[$];
   res_t  exp_q[$];
   res_t  got_q[$];
   longint row_sum = 0;
   int     row_cnt = 0;
   logic        hold_pending = 1'b0;
   logic [39:0] hold_data;
   logic        hold_last, hold_user;

   always #5 aclk = ~aclk;

   row_accumulator_axis dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast), .m_tuser(m_tuser), .o_overflow(o_overflow)
   );

   row_accumulator_axis #(.D_WIDTH(8), .LANES(4), .M_SIZE(4), .ACC_WIDTH(10)) dut_small (
      .aclk(aclk), .aresetn(aresetn),
      .s_tdata(s2_tdata), .s_tvalid(s2_tvalid), .s_tlast(s2_tlast), .s_tready(s2_tready),
      .m_tdata(m2_tdata), .m_tvalid(m2_tvalid), .m_tready(m2_tready),
      .m_tlast(m2_tlast), .m_tuser(m2_tuser), .o_overflow(o2_overflow)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] mk(input logic [31:0] a0, input logic [31:0] a1,
                                       input logic [31:0] a2, input logic [31:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   task automatic push_beat(input logic [127:0] d, input logic l);
      beat_t b;
      b.data = d;
      b.last = l;
      tx_q.push_back(b);
   endtask

   // Reference model: a row is the plain integer sum of all lanes of its beats.
   // It closes after 4 beats or on tlast and is truncated to 40 bits.
   task automatic model_push(input beat_t b);
      logic [31:0] e;
      res_t r;
      for (int l = 0; l < 4; l++) begin
         e = b.data[l*32 +: 32];
         row_sum += longint'($signed(e));
      end
      row_cnt++;
      if (row_cnt == 4 || b.last) begin
         r.data = row_sum[39:0];
         r.last = b.last;
         r.user = b.last && (row_cnt != 4);
         exp_q.push_back(r);
         row_sum = 0;
         row_cnt = 0;
      end
   endtask

   task automatic run(input int n, input int rdy_pct, input int gap_pct);
      res_t e, g;
      for (int c = 0; c < n; c++) begin
         @(negedge aclk);
         s_tvalid = (tx_q.size() > 0) && ($urandom_range(99) >= gap_pct);
         if (tx_q.size() > 0) begin
            s_tdata = tx_q[0].data;
            s_tlast = tx_q[0].last;
         end else begin
            s_tdata = '0;
            s_tlast = 1'b0;
         end
         m_tready = ($urandom_range(99) < rdy_pct);
         #1;
         cyc++;
         if (!s_tready) stall_cnt++;
         if (hold_pending) begin
            check("hold_valid", 64'(m_tvalid), 64'(1));
            check("hold_data", 64'(m_tdata), 64'(hold_data));
            check("hold_last", 64'(m_tlast), 64'(hold_last));
            check("hold_user", 64'(m_tuser), 64'(hold_user));
         end
         if (m_tvalid && m_tready) begin
            out_cyc = cyc;
            check("out_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("out_data", 64'(m_tdata), 64'(e.data));
               check("out_last", 64'(m_tlast), 64'(e.last));
               check("out_user", 64'(m_tuser), 64'(e.user));
            end
            g.data = m_tdata;
            g.last = m_tlast;
            g.user = m_tuser;
            got_q.push_back(g);
         end
         hold_pending = m_tvalid && !m_tready;
         hold_data = m_tdata;
         hold_last = m_tlast;
         hold_user = m_tuser;
         if (s_tvalid && s_tready) begin
            model_push(tx_q.pop_front());
            in_cnt++;
            in_cyc = cyc;
         end
      end
   endtask

   task automatic drain(input string tag, input int rdy_pct, input int gap_pct, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (tx_q.size() == 0 && exp_q.size() == 0) break;
         run(1, rdy_pct, gap_pct);
      end
      check(tag, 64'(tx_q.size() + exp_q.size()), 64'(0));
   endtask

   task automatic check_res(input string tag, input int idx, input logic [39:0] d,
                            input logic l, input logic u);
      if (idx < got_q.size()) begin
         check({tag, "_data"}, 64'(got_q[idx].data), 64'(d));
         check({tag, "_last"}, 64'(got_q[idx].last), 64'(l));
         check({tag, "_user"}, 64'(got_q[idx].user), 64'(u));
      end else begin
         check({tag, "_count"}, 64'(got_q.size()), 64'(idx + 1));
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_s_tready"}, 64'(s_tready), 64'(1));
      check({tag, "_m_tvalid"}, 64'(m_tvalid), 64'(0));
      check({tag, "_m_tlast"}, 64'(m_tlast), 64'(0));
      check({tag, "_m_tuser"}, 64'(m_tuser), 64'(0));
      check({tag, "_overflow"}, 64'(o_overflow), 64'(0));
      check({tag, "_m_tdata"}, 64'(m_tdata), 64'(0));
   endtask

   initial begin
      int n0, i0;
      logic        got;
      logic [9:0]  cap_data;
      logic        cap_last, cap_user;
      logic [9:0]  ovf_exp;
      logic [31:0] r0, r1, r2, r3;

      aresetn = 1'b0;
      s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
      s2_tdata = '0; s2_tvalid = 1'b0; s2_tlast = 1'b0; m2_tready = 1'b1;

      // Reset state.
      @(negedge aclk); #1;
      check_reset_vals("reset");
      @(negedge aclk);
      aresetn = 1'b1;

      // Basic row sum: {1,2,3,4} x4 = 40, one cycle of latency after the closing beat.
      n0 = got_q.size();
      for (int b = 0; b < 4; b++) push_beat(mk(32'd1, 32'd2, 32'd3, 32'd4), b == 3);
      drain("drain_basic", 100, 0, 40);
      check_res("basic", n0, 40'd40, 1'b1, 1'b0);
      check("basic_latency", 64'(out_cyc - in_cyc), 64'(2));

      // Signed back-to-back rows without a bubble.
      n0 = got_q.size();
      stall_cnt = 0;
      for (int b = 0; b < 4; b++) push_beat({4{32'hFFFF_FFFF}}, 1'b0);
      for (int b = 0; b < 4; b++) push_beat({4{32'd5}}, 1'b0);
      drain("drain_b2b", 100, 0, 40);
      check_res("b2b_a", n0, 40'hFF_FFFF_FFF0, 1'b0, 1'b0);
      check_res("b2b_b", n0 + 1, 40'd80, 1'b0, 1'b0);
      check("b2b_no_stall", 64'(stall_cnt), 64'(0));

      // Early tlast on beat 2, then a full row that has to start at count 0.
      n0 = got_q.size();
      push_beat({4{32'd1}}, 1'b0);
      push_beat({4{32'd1}}, 1'b1);
      for (int b = 0; b < 4; b++) push_beat({4{32'd1}}, b == 3);
      drain("drain_early", 100, 0, 40);
      check_res("early", n0, 40'd8, 1'b1, 1'b1);
      check_res("early_next", n0 + 1, 40'd16, 1'b1, 1'b0);

      // Backpressure: three rows offered while m_tready is held low.
      n0 = got_q.size();
      i0 = in_cnt;
      for (int r = 1; r <= 3; r++)
         for (int b = 0; b < 4; b++) push_beat({4{32'(r)}}, (r == 3) && (b == 3));
      run(10, 0, 0);
      check("bp_accepted", 64'(in_cnt - i0), 64'(5));
      check("bp_s_tready", 64'(s_tready), 64'(0));
      check("bp_m_tvalid", 64'(m_tvalid), 64'(1));
      check("bp_m_tdata", 64'(m_tdata), 64'(16));
      drain("drain_bp", 100, 0, 60);
      check_res("bp_row1", n0, 40'd16, 1'b0, 1'b0);
      check_res("bp_row2", n0 + 1, 40'd32, 1'b0, 1'b0);
      check_res("bp_row3", n0 + 2, 40'd48, 1'b1, 1'b0);

      // Randomized traffic with random gaps, backpressure and frame ends.
      for (int b = 0; b < 300; b++) begin
         r0 = $urandom(); r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
         push_beat(mk(r0, r1, r2, r3), (b == 299) || ($urandom_range(9) == 0));
      end
      drain("drain_random", 60, 25, 4000);
      check("random_no_overflow", 64'(o_overflow), 64'(0));

      // Reset mid-row: the partial sum is discarded.
      push_beat({4{32'd1}}, 1'b0);
      push_beat({4{32'd1}}, 1'b0);
      run(3, 100, 0);
      check("mid_accepted", 64'(tx_q.size()), 64'(0));
      @(negedge aclk);
      aresetn = 1'b0;
      s_tvalid = 1'b0;
      #1;
      check_reset_vals("mid_reset");
      row_sum = 0;
      row_cnt = 0;
      hold_pending = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      n0 = got_q.size();
      for (int b = 0; b < 4; b++) push_beat({4{32'd1}}, b == 3);
      drain("drain_mid", 100, 0, 40);
      check_res("mid_row", n0, 40'd16, 1'b1, 1'b0);

      // Overflow on the narrow instance: 4 beats of {127,127,127,127}.
`ifdef ACC_SATURATE_EN
      ovf_exp = 10'd511;
`else
      ovf_exp = 10'h3F0;
`endif
      for (int b = 0; b < 4; b++) begin
         @(negedge aclk);
         s2_tvalid = 1'b1;
         s2_tdata  = {4{8'd127}};
         s2_tlast  = (b == 3);
         #1;
         check("ovf_s_tready", 64'(s2_tready), 64'(1));
      end
      @(negedge aclk);
      s2_tvalid = 1'b0;
      s2_tlast  = 1'b0;
      got = 1'b0;
      cap_data = '0; cap_last = 1'b0; cap_user = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         #1;
         if (m2_tvalid) begin
            got = 1'b1;
            cap_data = m2_tdata;
            cap_last = m2_tlast;
            cap_user = m2_tuser;
         end else begin
            @(negedge aclk);
         end
      end
      check("ovf_result_seen", 64'(got), 64'(1));
      check("ovf_data", 64'(cap_data), 64'(ovf_exp));
      check("ovf_last", 64'(cap_last), 64'(1));
      check("ovf_user", 64'(cap_user), 64'(0));
      check("ovf_flag", 64'(o2_overflow), 64'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/row_accumulator_axis.md
# row_accumulator_axis

Parametrised, integer successor to the single-lane floating-point partial-row adder in the matrix-vector datapath. Each input beat carries `LANES` signed elements of a matrix-row product. The block sums the lanes, accumulates `M_SIZE` beats into one row sum, and emits that sum on an AXI-Stream master. Input and output use full valid/ready handshakes, and row and frame boundaries are tracked so downstream logic can assemble the result vector.

## Interface
- `D_WIDTH`, 32: width of one signed element.
- `LANES`, 4: elements per input beat; must be ≥1.
- `M_SIZE`, 4: beats per row; must be ≥1.
- `ACC_WIDTH`, 40: accumulator and result width; must be ≥ `D_WIDTH + clog2(LANES)`.
- `aclk`  in  1  clock; all logic is rising-edge.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `s_tdata`  in  `LANES*D_WIDTH`  packed signed elements; lane 0 is in bits [D_WIDTH-1:0].
- `s_tvalid`  in  1  input beat valid.
- `s_tlast`  in  1  last beat of the frame (the final row of the matrix).
- `s_tready`  out  1  block accepts a beat.
- `m_tdata`  out  `ACC_WIDTH`  signed row sum.
- `m_tvalid`  out  1  result valid.
- `m_tready`  in  1  downstream accepts the result.
- `m_tlast`  out  1  this result closes a frame.
- `m_tuser`  out  1  this row was closed early by `s_tlast` (fewer than `M_SIZE` beats).
- `o_overflow`  out  1  sticky; the accumulator exceeded the signed `ACC_WIDTH` range.

## Operation
- **Global advance:** `en = !m_tvalid || m_tready`, and `s_tready = en`. The pipeline registers and the beat counter update only when `en` is high.
- **Stage 1 (lane sum):**
  - On an accepted beat, sign-extend each lane to `ACC_WIDTH` and sum the lanes into a registered value.
  - Also register the stage-1 valid flag, a `close` flag, and the beat's `s_tlast`.
  - The lane sum cannot overflow, given the `ACC_WIDTH` constraint.
- **Beat counter:**
  - Counts 0..`M_SIZE-1` within a row.
  - `close` is set when the count equals `M_SIZE-1` or `s_tlast` is high.
  - On `close`, the counter returns to 0; otherwise it increments.
- **Stage 2 (accumulate):** when stage 1 is valid and `en` is high:
  - Compute `sum = acc + lane_sum`.
  - If `close` is clear: `acc <= sum`.
  - If `close` is set:
    - Load the output register with `sum`.
    - Set `m_tvalid = 1`, `m_tlast = last`, and `m_tuser = last && (count != M_SIZE-1)`.
    - Clear `acc` to 0.
- **Overflow:**
  - Detected on each stage-2 add: operands of equal sign producing a result of the opposite sign.
  - Sets `o_overflow`, which is cleared only by reset.
- **Output:** `m_tvalid` falls after a handshake unless a new result is loaded on the same edge.
- **`M_SIZE=1`:** every beat is a row.
- **`s_tlast` on a row's `M_SIZE`th beat:** `m_tlast=1`, `m_tuser=0`.

## Timing
- **Reset values:**
  - `s_tready` = 1.
  - `m_tvalid`, `m_tlast`, `m_tuser`, `o_overflow` = 0.
  - `m_tdata`, `acc`, and the counter = 0.
  - Stage-1 valid = 0.
- **Latency:** a closing beat accepted at edge k produces `m_tvalid` = 1 after edge k+1.
- **Throughput:** one beat per cycle while `m_tready` = 1.
- **Backpressure:**
  - While `m_tvalid && !m_tready`, all stages freeze and `s_tready` = 0.
  - No beat or result is lost or duplicated.
- `m_tdata`, `m_tlast`, and `m_tuser` are held stable while `m_tvalid && !m_tready`.
- **Simultaneous events:** an output handshake and a new result load on the same edge hand over without a bubble.
- **Reset mid-row:** the partial sum is discarded and the next accepted beat starts a new row at count 0.

## Configuration
- Macro: `ACC_SATURATE_EN`.
- **Defined:** on overflow, stage 2 clamps to the signed limits `2^(ACC_WIDTH-1)-1` or `-2^(ACC_WIDTH-1)`, and keeps accumulating from the clamped value.
- **Undefined:** the accumulator wraps (two's complement modulo `2^ACC_WIDTH`).
- `o_overflow` behaves identically in both builds.

## Test plan
- **Basic row sum** (defaults): 4 beats of lanes {1,2,3,4} with `s_tlast` on beat 4, `m_tready`=1 → `m_tdata`=40, `m_tlast`=1, `m_tuser`=0, `m_tvalid` one cycle after beat 4.
- **Signed, back-to-back rows:** row A all lanes -1, row B all lanes 5, with no gap → results -16 then 80 in consecutive order; `s_tready` stays 1.
- **Early `s_tlast`:** `s_tlast` on beat 2 of lanes {1,1,1,1} → `m_tdata`=8, `m_tuser`=1, `m_tlast`=1; the next beat starts a fresh row (count 0).
- **Backpressure:** `m_tready`=0 while 3 rows are offered → `s_tready` drops after row 1 completes and no data is lost; releasing `m_tready` yields rows 1–3 in order with sums intact.
- **Overflow** (`D_WIDTH`=8, `ACC_WIDTH`=10): 4 beats of lanes {127,127,127,127}:
  - With `ACC_SATURATE_EN` → `m_tdata`=511, `o_overflow`=1.
  - Without it → `m_tdata`=-16, `o_overflow`=1.
- **Reset mid-row:** assert `aresetn`=0 after beat 2, release, then send a full row of lanes {1,1,1,1} → `m_tdata`=16 and all outputs showed reset values during reset.
